// File: rtl/divider32_seq_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_pkg;

  // Number of trial-subtraction iterations for a 32-bit operand.
  localparam int DIV_ITERS = 32;

  // Iteration counter width (counts 0..DIV_ITERS-1).
  localparam int CNT_W = 5;

  // Controller states; encoding is fixed so it can be probed consistently.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/divider32_seq_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  // Shifted remainder carries one spare top bit so a shifted value with bit
  // WIDTH set is never mistaken for a negative trial result.
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] diff;

  // Trial subtraction; keep the difference only when it did not borrow.
  always_comb begin
    r_sh = {r_in, q_in[WIDTH-1]};
    diff = r_sh - {2'b00, d_in};
    if (!diff[WIDTH+1]) begin
      r_out = diff[WIDTH:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      r_out = r_sh[WIDTH:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider32_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU): quotient to LO, remainder to HI.
module divider32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     step_r;
  logic [WIDTH-1:0]   step_q;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (dvs_q),
    .r_out (step_r),
    .q_out (step_q)
  );

  // Operand magnitudes; 0x80000000 maps to itself, which is correct unsigned.
  always_comb begin
    dividend_mag = (signed_en && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (signed_en && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Next-state logic: zero divisor skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (divisor == '0) ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = S_FIXUP;
      S_FIXUP:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates: operand capture, iteration, sign fixup into the result registers.
  always_comb begin
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          r_d       = '0;
          q_d       = dividend_mag;
          dvs_d     = divisor_mag;
          neg_quo_d = signed_en && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_en && dividend[WIDTH-1];
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end
        end
      end
      S_DIVIDE: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIXUP: begin
        quotient_d  = neg_quo_q ? -q_q : q_q;
        remainder_d = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        div_zero_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from the registered state; results come straight from flops.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    quotient  = quotient_q;
    remainder = remainder_q;
    div_zero  = div_zero_q;
  end

endmodule

// File: tb/tb_divider32_seq.sv
// Self-checking bench for divider32_seq: directed cases then random DIV/DIVU ops.
module tb_divider32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_en = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  // Results the outputs must be holding between completions.
  logic [31:0] held_q = '0;
  logic [31:0] held_r = '0;
  logic [31:0] held_z = '0;

  divider32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_en (signed_en),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on sign-extended 64-bit values (truncating division).
  task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      sq = sa / sb;
      sr = sa % sb;
      q = sq[31:0];
      r = sr[31:0];
    end
  endtask

  // One operation; poke_at pulses a stray start, abort_at pulls reset (0 = never).
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at, input int abort_at);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc;
    int          exp_lat;
    bit          aborted;
    model(s, a, b, eq, er, ez);
    exp_lat = (b == 32'd0) ? 1 : 34;
    signed_en = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    // Scramble inputs so the design must rely on its latched copies.
    signed_en = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = $urandom;
    cyc = 1;
    aborted = 0;
    while (done !== 1'b1 && cyc < 60) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      if (cyc == 5) begin
        chk("hold_quotient", quotient, held_q);
        chk("hold_remainder", remainder, held_r);
        chk("hold_div_zero", {31'd0, div_zero}, held_z);
      end
      if (cyc == poke_at) begin
        start    = 1'b1;
        dividend = 32'h0000_DEAD;
        divisor  = 32'd3;
      end
      if (cyc == abort_at) begin
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      held_q = '0;
      held_r = '0;
      held_z = '0;
      @(posedge clk); #1;
      chk("post_abort_done", {31'd0, done}, 32'd0);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
      $display("op s=%0d %h / %h aborted by reset at cycle %0d", s, a, b, abort_at);
      return;
    end
    chk("latency", cyc, exp_lat);
    chk("busy_done", {31'd0, busy}, 32'd1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_zero", {31'd0, div_zero}, {31'd0, ez});
    held_q = eq;
    held_r = er;
    held_z = {31'd0, ez};
    $display("op s=%0d %h / %h -> q=%h r=%h z=%0d done@%0d", s, a, b, quotient, remainder, div_zero, cyc);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_quotient", quotient, held_q);
    chk("idle_remainder", remainder, held_r);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    int          mode;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases; each op starts in the idle cycle right after the previous DONE.
    do_op(1'b0, 32'd100, 32'd7, 0, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(1'b0, 32'h0000_1234, 32'd0, 0, 0);
    do_op(1'b0, 32'd100, 32'd7, 0, 0);
    do_op(1'b1, 32'hFFFF_FFF0, 32'd0, 0, 0);
    do_op(1'b1, 32'd1000, 32'd33, 10, 0);
    do_op(1'b0, 32'd100, 32'd7, 0, 20);
    do_op(1'b0, 32'd100, 32'd7, 0, 0);

    // Random mix of signed/unsigned, small, large and zero divisors.
    for (int i = 0; i < 40; i++) begin
      rs   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0)      rb = 32'd0;
      else if (mode < 4)  rb = $urandom_range(1, 15);
      else if (mode < 6)  rb = -($urandom_range(1, 15));
      else                rb = $urandom >> $urandom_range(0, 31);
      do_op(rs, ra, rb, (i % 7 == 3) ? 12 : 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
